keccak_sponge_ctrl: RTL

KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

---
 rtl/keccak_sponge_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// SHAKE128/SHAKE256 sponge sequencer: absorbs 64-bit lanes, pads, drives Keccak-f and squeezes lanes.
// Optional SPONGE_STATE_CLR_EN adds a one-cycle CLEAR state that pulses state_clr_o after start.
`timescale 1ns/1ps
module keccak_sponge_ctrl #(
  parameter int RATE128 = 21,
  parameter int RATE256 = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [15:0] out_lanes_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [63:0] in_data_i,
  input  logic        in_last_i,
  output logic [4:0]  lane_idx_o,
  output logic        lane_xor_en_o,
  output logic [63:0] lane_xor_data_o,
  output logic        state_clr_o,
  output logic        perm_start_o,
  input  logic        perm_done_i,
  input  logic [63:0] state_rd_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  state_o
);

  // Both lane streams are valid/ready: a lane moves on a rising edge where valid and ready are both high;
  // the producer holds valid and data steady until that edge.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
`ifdef SPONGE_STATE_CLR_EN
    S_CLEAR   = 3'd1,
`endif
    S_ABSORB  = 3'd2,
    S_PAD     = 3'd3,
    S_PERM    = 3'd4,
    S_SQUEEZE = 3'd5
  } state_t;

  localparam logic [4:0] R128 = 5'(RATE128);
  localparam logic [4:0] R256 = 5'(RATE256);
  localparam logic [63:0] PAD_LO   = 64'h0000_0000_0000_001F;
  localparam logic [63:0] PAD_HI   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] PAD_BOTH = 64'h8000_0000_0000_001F;

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic        mode_q, mode_d;
  logic        pad_hi_q, pad_hi_d;
  logic        perm_start_q, perm_start_d;
  logic        done_q, done_d;

  logic [4:0]  rate;
  logic [4:0]  cnt_inc;
  logic        out_valid;

  assign rate    = mode_q ? R256 : R128;
  assign cnt_inc = 5'(cnt_q + 5'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      ret_q        <= S_ABSORB;
      cnt_q        <= '0;
      rem_q        <= '0;
      mode_q       <= 1'b0;
      pad_hi_q     <= 1'b0;
      perm_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      pad_hi_q     <= pad_hi_d;
      perm_start_q <= perm_start_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ret_d           = ret_q;
    cnt_d           = cnt_q;
    rem_d           = rem_q;
    mode_d          = mode_q;
    pad_hi_d        = pad_hi_q;
    done_d          = 1'b0;
    in_ready_o      = 1'b0;
    lane_idx_o      = '0;
    lane_xor_en_o   = 1'b0;
    lane_xor_data_o = '0;
    state_clr_o     = 1'b0;
    out_valid       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = mode_i;
          rem_d    = (out_lanes_i == 16'd0) ? 16'd1 : out_lanes_i;
          cnt_d    = '0;
          pad_hi_d = 1'b0;
`ifdef SPONGE_STATE_CLR_EN
          state_d  = S_CLEAR;
`else
          state_d  = S_ABSORB;
`endif
        end
      end
`ifdef SPONGE_STATE_CLR_EN
      S_CLEAR: begin
        state_clr_o = 1'b1;
        state_d     = S_ABSORB;
      end
`endif
      S_ABSORB: begin
        in_ready_o = 1'b1;
        lane_idx_o = cnt_q;
        if (in_valid_i) begin
          lane_xor_en_o   = 1'b1;
          lane_xor_data_o = in_data_i;
          // A full block forces a permutation first; a last lane then pads from lane 0.
          if (cnt_inc == rate) begin
            cnt_d   = '0;
            state_d = S_PERM;
            ret_d   = in_last_i ? S_PAD : S_ABSORB;
          end else begin
            cnt_d = cnt_inc;
            if (in_last_i) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        lane_xor_en_o = 1'b1;
        if (pad_hi_q || (cnt_q == 5'(rate - 5'd1))) begin
          lane_idx_o      = 5'(rate - 5'd1);
          lane_xor_data_o = pad_hi_q ? PAD_HI : PAD_BOTH;
          pad_hi_d        = 1'b0;
          cnt_d           = '0;
          ret_d           = S_SQUEEZE;
          state_d         = S_PERM;
        end else begin
          lane_idx_o      = cnt_q;
          lane_xor_data_o = PAD_LO;
          pad_hi_d        = 1'b1;
        end
      end
      S_PERM: begin
        if (perm_done_i) state_d = ret_q;
      end
      S_SQUEEZE: begin
        out_valid  = 1'b1;
        lane_idx_o = cnt_q;
        if (out_ready_i) begin
          rem_d = 16'(rem_q - 16'd1);
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else if (cnt_inc == rate) begin
            cnt_d   = '0;
            ret_d   = S_SQUEEZE;
            state_d = S_PERM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    perm_start_d = (state_d == S_PERM) && (state_q != S_PERM);
  end

  assign perm_start_o = perm_start_q;
  assign done_o       = done_q;
  assign out_valid_o  = out_valid;
  assign out_data_o   = out_valid ? state_rd_data_i : 64'd0;
  assign busy_o       = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule
